// File: rtl/led_seq_cpu_if.sv
// Program-load and restart bus for led_seq_cpu: a testbench or loader drives the master side.
interface led_seq_cpu_if #(
    parameter int ADDR_W = 11
) ();
    logic              start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output start,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input start,
        input wr_en,
        input wr_addr,
        input wr_data
    );
endinterface

// File: rtl/led_seq_cpu.sv
// led_seq_cpu: microcoded LED sequencer running 32-bit instructions from on-chip RAM.
// Defining SEQ_CALL_EN adds single-level CALL (0x7) / RET (0x8); otherwise both are illegal.
module led_seq_cpu #(
    parameter int    ADDR_W         = 11,
    parameter int    NUM_LEDS       = 4,
    parameter int    STARTUP_CYCLES = 16000,
    parameter string INIT_FILE      = ""
) (
    input  logic                CLK,
    input  logic                RST_N,
    led_seq_cpu_if.slave        bus,
    output logic [NUM_LEDS-1:0] LED,
    output logic                halted,
    output logic                err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SC_W  = (STARTUP_CYCLES < 2) ? 1 : $clog2(STARTUP_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_INIT = SC_W'(STARTUP_CYCLES);

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_DELAY  = 4'h1;
    localparam logic [3:0] OP_SET    = 4'h2;
    localparam logic [3:0] OP_JUMP   = 4'h3;
    localparam logic [3:0] OP_LOADC  = 4'h4;
    localparam logic [3:0] OP_DJNZ   = 4'h5;
    localparam logic [3:0] OP_TOGGLE = 4'h6;
    localparam logic [3:0] OP_HALT   = 4'hF;
`ifdef SEQ_CALL_EN
    localparam logic [3:0] OP_CALL   = 4'h7;
    localparam logic [3:0] OP_RET    = 4'h8;
`endif

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_FETCH,
        ST_EXEC,
        ST_DELAY,
        ST_HALT
    } state_t;

    state_t            state_r;
    logic [SC_W-1:0]   startup_r;
    logic [ADDR_W-1:0] pc_r;
    logic [15:0]       cnt_r;
    logic [27:0]       delay_r;
    logic [31:0]       rd_data_r;
    logic [31:0]       mem_r [DEPTH];
`ifdef SEQ_CALL_EN
    logic [ADDR_W-1:0] ret_r;
`endif

    logic [3:0]        opcode_s;
    logic [27:0]       operand_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] jmp_tgt_s;
    logic [15:0]       cnt_dec_s;

    // Program RAM: write port lives outside reset so loads work in any state; read is read-before-write
    always_ff @(posedge CLK) begin
        if (bus.wr_en) begin
            mem_r[bus.wr_addr] <= bus.wr_data;
        end
        rd_data_r <= mem_r[pc_r];
    end

    // Field split and next-pc candidates for the word captured during FETCH
    always_comb begin
        opcode_s  = rd_data_r[31:28];
        operand_s = rd_data_r[27:0];
        pc_inc_s  = pc_r + ADDR_W'(1);
        jmp_tgt_s = operand_s[ADDR_W-1:0];
        cnt_dec_s = cnt_r - 16'd1;
    end

    // Sequencer state machine; all outputs registered here
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= ST_STARTUP;
            startup_r <= SC_INIT;
            pc_r      <= '0;
            cnt_r     <= 16'd0;
            delay_r   <= 28'd0;
            LED       <= '0;
            halted    <= 1'b0;
            err       <= 1'b0;
`ifdef SEQ_CALL_EN
            ret_r     <= '0;
`endif
        end else begin
            case (state_r)
                ST_STARTUP: begin
                    if (startup_r == '0) begin
                        state_r <= ST_FETCH;
                    end else begin
                        startup_r <= startup_r - SC_W'(1);
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    state_r <= ST_FETCH;
                    case (opcode_s)
                        OP_NOP: begin
                            pc_r <= pc_inc_s;
                        end
                        OP_DELAY: begin
                            delay_r <= operand_s;
                            pc_r    <= pc_inc_s;
                            state_r <= ST_DELAY;
                        end
                        OP_SET: begin
                            LED  <= operand_s[NUM_LEDS-1:0];
                            pc_r <= pc_inc_s;
                        end
                        OP_JUMP: begin
                            pc_r <= jmp_tgt_s;
                        end
                        OP_LOADC: begin
                            cnt_r <= operand_s[15:0];
                            pc_r  <= pc_inc_s;
                        end
                        OP_DJNZ: begin
                            // A zero counter wraps to 0xFFFF and keeps looping
                            cnt_r <= cnt_dec_s;
                            pc_r  <= (cnt_dec_s != 16'd0) ? jmp_tgt_s : pc_inc_s;
                        end
                        OP_TOGGLE: begin
                            LED  <= LED ^ operand_s[NUM_LEDS-1:0];
                            pc_r <= pc_inc_s;
                        end
                        OP_HALT: begin
                            halted  <= 1'b1;
                            state_r <= ST_HALT;
                        end
`ifdef SEQ_CALL_EN
                        OP_CALL: begin
                            ret_r <= pc_inc_s;
                            pc_r  <= jmp_tgt_s;
                        end
                        OP_RET: begin
                            pc_r <= ret_r;
                        end
`endif
                        default: begin
                            // Illegal opcode: pc stays on the offending word
                            halted  <= 1'b1;
                            err     <= 1'b1;
                            state_r <= ST_HALT;
                        end
                    endcase
                end
                ST_DELAY: begin
                    if (delay_r == 28'd0) begin
                        state_r <= ST_FETCH;
                    end else begin
                        delay_r <= delay_r - 28'd1;
                    end
                end
                ST_HALT: begin
                    if (bus.start) begin
                        pc_r    <= '0;
                        err     <= 1'b0;
                        halted  <= 1'b0;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                default: begin
                    state_r <= ST_STARTUP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_seq_cpu.sv
// Self-checking bench for led_seq_cpu: directed vector table, hand-written multi-cycle
// sequences, and random programs checked against an instruction-timeline model.
module tb_led_seq_cpu;
    localparam int AW     = 6;
    localparam int NL     = 4;
    localparam int SC     = 4;
    localparam int DEPTH  = 1 << AW;
    localparam int BUDGET = 240;
    localparam logic [31:0] W_HALT = 32'hF000_0000;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [NL-1:0] LED;
    logic          halted;
    logic          err;

    led_seq_cpu_if #(.ADDR_W(AW)) bus ();

    led_seq_cpu #(
        .ADDR_W(AW), .NUM_LEDS(NL), .STARTUP_CYCLES(SC), .INIT_FILE("")
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus), .LED(LED), .halted(halted), .err(err)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cur_edge = 0;

    logic [31:0] model_mem [DEPTH];
    logic [3:0]  exp_led  [BUDGET+1];
    logic        exp_halt [BUDGET+1];
    logic        exp_err  [BUDGET+1];

    typedef struct {
        logic [3:0][31:0] prog;
        int               edge_no;
        logic [3:0]       led;
        logic             halted;
        logic             err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [27:0] opr);
        return {op, opr};
    endfunction

    function automatic vec_t mkv(input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [31:0] w3,
                                 input int e, input logic [3:0] l, input logic h, input logic er);
        vec_t v;
        v.prog    = {w3, w2, w1, w0};
        v.edge_no = e;
        v.led     = l;
        v.halted  = h;
        v.err     = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cur_edge);
        end
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        @(posedge CLK);
        #1;
        bus.wr_en   = 1'b0;
    endtask

    // Hold reset, copy model_mem into the DUT, then release on a falling edge
    task automatic load_and_start();
        RST_N = 1'b0;
        for (int a = 0; a < DEPTH; a++) write_word(a, model_mem[a]);
        @(negedge CLK);
        RST_N = 1'b1;
        cur_edge = 0;
    endtask

    task automatic goto_edge(input int k);
        while (cur_edge < k) begin
            @(posedge CLK);
            #1;
            cur_edge++;
        end
    endtask

    task automatic set_prog4(input logic [3:0][31:0] p);
        for (int a = 0; a < DEPTH; a++) model_mem[a] = (a < 4) ? p[a] : W_HALT;
    endtask

    // Instruction-level timeline: each instruction acts on its EXEC edge, the next EXEC
    // edge follows after 2 cycles (n+3 for DELAY n); the first EXEC edge is SC+3.
    task automatic model_run();
        int pc, cnt, next_exec, cost, npc, opi;
        logic [3:0] led;
        logic h, e, stopped;
        logic [31:0] w;
`ifdef SEQ_CALL_EN
        int ret = 0;
`endif
        pc = 0; cnt = 0; led = 4'h0; h = 1'b0; e = 1'b0; stopped = 1'b0;
        next_exec = SC + 3;
        for (int k = 1; k <= BUDGET; k++) begin
            if (!stopped && k == next_exec) begin
                w    = model_mem[pc];
                opi  = int'(w[27:0]);
                cost = 2;
                npc  = (pc + 1) % DEPTH;
                case (w[31:28])
                    4'h0: ;
                    4'h1: cost = opi + 3;
                    4'h2: led = w[3:0];
                    4'h3: npc = opi % DEPTH;
                    4'h4: cnt = opi % 65536;
                    4'h5: begin
                        cnt = (cnt + 65535) % 65536;
                        if (cnt != 0) npc = opi % DEPTH;
                    end
                    4'h6: led = led ^ w[3:0];
                    4'hF: begin h = 1'b1; stopped = 1'b1; npc = pc; end
`ifdef SEQ_CALL_EN
                    4'h7: begin ret = npc; npc = opi % DEPTH; end
                    4'h8: npc = ret;
`endif
                    default: begin h = 1'b1; e = 1'b1; stopped = 1'b1; npc = pc; end
                endcase
                pc = npc;
                next_exec += cost;
            end
            exp_led[k]  = led;
            exp_halt[k] = h;
            exp_err[k]  = e;
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [27:0] r28;
        r28 = 28'($urandom);
        case ($urandom_range(0, 9))
            0: return ins(4'h0, r28);
            1: return ins(4'h1, 28'($urandom_range(0, 6)));
            2: return ins(4'h2, r28);
            3: return ins(4'h3, r28);
            4: return ins(4'h4, {r28[27:16], 16'($urandom_range(0, 4))});
            5: return ins(4'h5, r28);
            6: return ins(4'h6, r28);
            7: return W_HALT;
            8: return ins(4'($urandom_range(7, 14)), r28);
            default: return ins(4'h2, r28);
        endcase
    endfunction

    initial begin
        RST_N       = 1'b0;
        bus.start   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = 32'h0;

        // Directed table: {program, edge after reset release, LED, halted, err}
        vecs.push_back(mkv(ins(4'h2, 28'h5), W_HALT, W_HALT, W_HALT, SC + 2, 4'h0, 1'b0, 1'b0));
        vecs.push_back(mkv(ins(4'h2, 28'h5), W_HALT, W_HALT, W_HALT, SC + 3, 4'h5, 1'b0, 1'b0));
        vecs.push_back(mkv(ins(4'h2, 28'h5), W_HALT, W_HALT, W_HALT, SC + 4, 4'h5, 1'b0, 1'b0));
        vecs.push_back(mkv(ins(4'h2, 28'h5), W_HALT, W_HALT, W_HALT, SC + 5, 4'h5, 1'b1, 1'b0));
        vecs.push_back(mkv(ins(4'h2, 28'h1), ins(4'h1, 28'd10), ins(4'h2, 28'h0), W_HALT, SC + 17, 4'h1, 1'b0, 1'b0));
        vecs.push_back(mkv(ins(4'h2, 28'h1), ins(4'h1, 28'd10), ins(4'h2, 28'h0), W_HALT, SC + 18, 4'h0, 1'b0, 1'b0));
        vecs.push_back(mkv(ins(4'h2, 28'h1), ins(4'h1, 28'd10), ins(4'h2, 28'h0), W_HALT, SC + 20, 4'h0, 1'b1, 1'b0));
        vecs.push_back(mkv(ins(4'h4, 28'd3), ins(4'h6, 28'h1), ins(4'h5, 28'h1), W_HALT, SC + 16, 4'h1, 1'b0, 1'b0));
        vecs.push_back(mkv(ins(4'h4, 28'd3), ins(4'h6, 28'h1), ins(4'h5, 28'h1), W_HALT, SC + 17, 4'h1, 1'b1, 1'b0));
        vecs.push_back(mkv(ins(4'h0, 28'h0), ins(4'h0, 28'h0), 32'h9000_0000, W_HALT, SC + 6, 4'h0, 1'b0, 1'b0));
        vecs.push_back(mkv(ins(4'h0, 28'h0), ins(4'h0, 28'h0), 32'h9000_0000, W_HALT, SC + 7, 4'h0, 1'b1, 1'b1));
        vecs.push_back(mkv(ins(4'h2, 28'h3), ins(4'h3, 28'hFFF_FFC3), ins(4'h2, 28'hF), W_HALT, SC + 7, 4'h3, 1'b1, 1'b0));
        vecs.push_back(mkv(ins(4'h2, 28'hFFF_FFF5), ins(4'h6, 28'hABC_DEF3), W_HALT, W_HALT, SC + 7, 4'h6, 1'b1, 1'b0));
        vecs.push_back(mkv(ins(4'h6, 28'h1), ins(4'h5, 28'h0), W_HALT, W_HALT, SC + 12, 4'h1, 1'b0, 1'b0));
`ifdef SEQ_CALL_EN
        vecs.push_back(mkv(ins(4'h7, 28'h5), W_HALT, W_HALT, W_HALT, SC + 5, 4'h0, 1'b1, 1'b0));
`else
        vecs.push_back(mkv(ins(4'h7, 28'h5), W_HALT, W_HALT, W_HALT, SC + 3, 4'h0, 1'b1, 1'b1));
`endif

        foreach (vecs[i]) begin
            set_prog4(vecs[i].prog);
            load_and_start();
            goto_edge(vecs[i].edge_no);
            check($sformatf("vec%0d_led", i), 32'(LED), 32'(vecs[i].led));
            check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].halted));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
        end

        // Illegal opcode, start ignored while running, restart and read-before-write
        set_prog4({W_HALT, 32'h9000_0000, ins(4'h0, 28'h0), ins(4'h0, 28'h0)});
        load_and_start();
        goto_edge(SC + 4);
        bus.start = 1'b1;
        goto_edge(SC + 5);
        bus.start = 1'b0;
        goto_edge(SC + 8);
        check("illegal_halted", 32'(halted), 32'h1);
        check("illegal_err", 32'(err), 32'h1);
        write_word(0, ins(4'h2, 28'hA));
        write_word(1, W_HALT);
        check("halted_during_write", 32'(halted), 32'h1);
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        check("start_clears_err", 32'(err), 32'h0);
        check("start_clears_halted", 32'(halted), 32'h0);
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = ins(4'h2, 28'h6);
        @(posedge CLK); #1;
        bus.wr_en = 1'b0;
        @(posedge CLK); #1;
        check("restart_old_word_led", 32'(LED), 32'hA);
        repeat (2) @(posedge CLK);
        #1;
        check("restart_halt", 32'(halted), 32'h1);
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rewritten_word_led", 32'(LED), 32'h6);

        // Reset asserted in the middle of a long DELAY
        set_prog4({W_HALT, W_HALT, ins(4'h1, 28'd1000), ins(4'h2, 28'hF)});
        load_and_start();
        goto_edge(SC + 16);
        check("pre_reset_led", 32'(LED), 32'hF);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset_led", 32'(LED), 32'h0);
        check("async_reset_halted", 32'(halted), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        cur_edge = 0;
        goto_edge(SC + 2);
        check("rerun_led_before_exec", 32'(LED), 32'h0);
        goto_edge(SC + 3);
        check("rerun_led_at_exec", 32'(LED), 32'hF);

`ifdef SEQ_CALL_EN
        // CALL into a subroutine and RET back to caller+1
        for (int a = 0; a < DEPTH; a++) model_mem[a] = W_HALT;
        model_mem[0] = ins(4'h7, 28'h4);
        model_mem[1] = ins(4'h2, 28'h9);
        model_mem[4] = ins(4'h2, 28'h3);
        model_mem[5] = ins(4'h8, 28'h0);
        load_and_start();
        goto_edge(SC + 5);
        check("call_sub_led", 32'(LED), 32'h3);
        goto_edge(SC + 9);
        check("ret_caller_led", 32'(LED), 32'h9);
        goto_edge(SC + 11);
        check("ret_halted", 32'(halted), 32'h1);
        check("ret_err", 32'(err), 32'h0);
`endif

        // Random programs against the instruction-timeline model
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++) model_mem[a] = rand_word();
            model_run();
            load_and_start();
            for (int k = 1; k <= BUDGET; k++) begin
                goto_edge(k);
                check($sformatf("rand%0d_led", r), 32'(LED), 32'(exp_led[k]));
                check($sformatf("rand%0d_halted", r), 32'(halted), 32'(exp_halt[k]));
                check($sformatf("rand%0d_err", r), 32'(err), 32'(exp_err[k]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
